// File: rtl/gb_xact_master.sv
// Ghostbus transaction master: turns single or burst commands into registered bus strobes,
// captures read data after RD_LAT cycles, and counts verify-mode mismatches.
module gb_xact_master #(
    parameter int GB_AW  = 24,
    parameter int GB_DW  = 32,
    parameter int RD_LAT = 2,
    parameter int LENW   = 8,
    parameter int ECW    = 16
) (
    input  logic             gb_clk,
    input  logic             gb_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [GB_AW-1:0] cmd_addr,
    input  logic [GB_DW-1:0] cmd_wdata,
    input  logic [GB_DW-1:0] cmd_mask,
    input  logic [LENW-1:0]  cmd_len,
    input  logic             cmd_inc,
    output logic             rsp_valid,
    output logic [GB_AW-1:0] rsp_addr,
    output logic [GB_DW-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    input  logic             err_clr,
    output logic [ECW-1:0]   err_count,
    output logic [GB_AW-1:0] gb_addr,
    output logic [GB_DW-1:0] gb_wdata,
    output logic             gb_wen,
    output logic             gb_rstb,
    input  logic [GB_DW-1:0] gb_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_WAIT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t           r_state, w_next;
    logic             r_ready, r_busy, r_wen, r_rstb;
    logic             r_wrop, r_vfy, r_inc;
    logic [LENW-1:0]  r_len, r_beat;
    logic [GB_AW-1:0] r_addr;
    logic [GB_DW-1:0] r_wdata, r_mask;
    logic [3:0]       r_wcnt;
    logic             r_rsp_valid, r_rsp_err;
    logic [GB_AW-1:0] r_rsp_addr;
    logic [GB_DW-1:0] r_rsp_data;
    logic [ECW-1:0]   r_ecnt;

    logic w_accept, w_last, w_wait_done, w_rsp, w_advance, w_mis, w_pulse;

    assign w_accept    = cmd_valid & r_ready;
    assign w_last      = (r_beat == r_len);
    assign w_wait_done = (r_wcnt == LAT_M1);
    assign w_rsp       = (r_state == S_WAIT) && w_wait_done;
    assign w_advance   = ((r_state == S_WR) && !r_vfy && !w_last) || (w_rsp && !w_last);
    assign w_mis       = r_vfy & (|((gb_rdata ^ r_wdata) & r_mask));
    assign w_pulse     = r_rsp_valid & r_rsp_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (cmd_op == 2'd0 || cmd_op == 2'd2) ? S_WR : S_RD;
            S_WR:   w_next = r_vfy ? S_RD : (w_last ? S_IDLE : S_WR);
            S_RD:   w_next = S_WAIT;
            S_WAIT: if (w_wait_done) w_next = w_last ? S_IDLE : (r_wrop ? S_WR : S_RD);
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes and ready/busy are decoded from the next state so they are true flops.
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_wen       <= 1'b0;
            r_rstb      <= 1'b0;
            r_wrop      <= 1'b0;
            r_vfy       <= 1'b0;
            r_inc       <= 1'b0;
            r_len       <= '0;
            r_beat      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_wcnt      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_ecnt      <= '0;
        end else begin
            r_state     <= w_next;
            r_ready     <= (w_next == S_IDLE);
            r_busy      <= (w_next != S_IDLE);
            r_wen       <= (w_next == S_WR);
            r_rstb      <= (w_next == S_RD);
            r_rsp_valid <= w_rsp;
            if (w_rsp) begin
                r_rsp_addr <= r_addr;
                r_rsp_data <= gb_rdata;
                r_rsp_err  <= w_mis;
            end
            if (r_state == S_RD)
                r_wcnt <= '0;
            else if (r_state == S_WAIT)
                r_wcnt <= r_wcnt + 4'd1;
            if (w_accept) begin
                r_wrop  <= (cmd_op == 2'd0 || cmd_op == 2'd2);
                r_vfy   <= (cmd_op == 2'd2);
                r_inc   <= cmd_inc;
                r_len   <= cmd_len;
                r_beat  <= '0;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_mask  <= cmd_mask;
            end else if (w_advance) begin
                r_beat <= r_beat + LENW'(1);
                if (r_inc) begin
                    r_addr  <= r_addr + GB_AW'(1);
                    r_wdata <= r_wdata + GB_DW'(1);
                end
            end
            // Counts the visible rsp_err pulse, so a clear in that same cycle leaves 1.
            if (err_clr)
                r_ecnt <= ECW'(w_pulse);
            else if (w_pulse && r_ecnt != '1)
                r_ecnt <= r_ecnt + ECW'(1);
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign gb_wen    = r_wen;
    assign gb_rstb   = r_rstb;
    assign gb_addr   = r_addr;
    assign gb_wdata  = r_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign err_count = r_ecnt;

endmodule

// File: tb/tb_gb_xact_master.sv
// Directed bench for gb_xact_master: single-beat vector table plus burst, wrap, verify,
// error-counter and mid-burst reset sequences against a fixed-latency bus model.
module tb_gb_xact_master;

    localparam int AW = 24, DW = 32, LAT = 2, LW = 8, EC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_inc, busy, err_clr;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr, rsp_addr, gb_addr;
    logic [DW-1:0] cmd_wdata, cmd_mask, rsp_data, gb_wdata, gb_rdata;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid, rsp_err, gb_wen, gb_rstb;
    logic [EC-1:0] err_count;

    always #5 clk = ~clk;

    gb_xact_master #(.GB_AW(AW), .GB_DW(DW), .RD_LAT(LAT), .LENW(LW), .ECW(EC)) dut (
        .gb_clk(clk), .gb_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .cmd_len(cmd_len), .cmd_inc(cmd_inc), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .err_clr(err_clr),
        .err_count(err_count), .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen),
        .gb_rstb(gb_rstb), .gb_rdata(gb_rdata)
    );

    // Bus model: data is valid only in the cycle exactly LAT cycles after the rstb cycle.
    int          rs_total = 0;
    int          rd_cd = 0;
    logic [31:0] rd_val = '0;
    logic [31:0] rd_tab [0:63];

    always @(posedge clk) begin
        if (gb_rstb) begin
            rd_cd    <= LAT;
            rd_val   <= rd_tab[rs_total % 64];
            rs_total <= rs_total + 1;
        end else if (rd_cd > 0) begin
            rd_cd <= rd_cd - 1;
        end
    end
    assign gb_rdata = (rd_cd == 1) ? rd_val : 32'h0BAD0BAD;

    int checks = 0, failures = 0;

    int          wen_c [0:299];
    logic [23:0] wen_a [0:299];
    logic [31:0] wen_d [0:299];
    int          rs_c  [0:299];
    logic [23:0] rs_a  [0:299];
    int          rsp_c [0:15];
    logic [23:0] rsp_a [0:15];
    logic [31:0] rsp_d [0:15];
    logic        rsp_e [0:15];
    int n_wen, n_rs, n_rsp, rdy_c, n_overlap, n_busy_bad;
    bit clr_on_rsp = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_rd(input int k, input logic [31:0] v);
        rd_tab[(rs_total + k) % 64] = v;
    endtask

    task automatic chk_zero_all(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_gb_wen"},    gb_wen, 0);
        chk({tag, "_gb_rstb"},   gb_rstb, 0);
        chk({tag, "_gb_addr"},   gb_addr, 0);
        chk({tag, "_gb_wdata"},  gb_wdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_addr"},  rsp_addr, 0);
        chk({tag, "_rsp_data"},  rsp_data, 0);
        chk({tag, "_rsp_err"},   rsp_err, 0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask

    // Issue one command, then log every strobe/response per cycle (cycle 1 = cycle after accept).
    task automatic run(input logic [1:0] op, input logic [23:0] a, input logic [31:0] wd,
                       input logic [31:0] mk, input logic [7:0] len, input logic inc, input int maxc);
        int w;
        n_wen = 0; n_rs = 0; n_rsp = 0; rdy_c = -1; n_overlap = 0; n_busy_bad = 0;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL ready_wait: cmd_ready got 0 expected 1");
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
        cmd_len = len; cmd_inc = inc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_addr = ~a; cmd_wdata = ~wd; cmd_mask = ~mk;
        cmd_len = ~len; cmd_inc = ~inc;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            err_clr = 1'b0;
            if (gb_wen && n_wen < 300) begin
                wen_c[n_wen] = c; wen_a[n_wen] = gb_addr; wen_d[n_wen] = gb_wdata; n_wen++;
            end
            if (gb_rstb && n_rs < 300) begin
                rs_c[n_rs] = c; rs_a[n_rs] = gb_addr; n_rs++;
            end
            if (gb_wen && gb_rstb) n_overlap++;
            if (busy === cmd_ready) n_busy_bad++;
            if (rsp_valid) begin
                if (n_rsp < 16) begin
                    rsp_c[n_rsp] = c; rsp_a[n_rsp] = rsp_addr; rsp_d[n_rsp] = rsp_data;
                    rsp_e[n_rsp] = rsp_err;
                end
                n_rsp++;
                if (clr_on_rsp) err_clr = 1'b1;
            end
            if (cmd_ready) begin
                rdy_c = c;
                break;
            end
        end
        if (rdy_c < 0) begin
            checks++; failures++;
            $display("FAIL cmd_timeout: cmd_ready not seen within %0d cycles", maxc);
        end
        chk("wen_rstb_overlap", n_overlap, 0);
        chk("busy_not_inverse", n_busy_bad, 0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [23:0] a;
        logic [31:0] wd, mk, rdv;
        int          ew;    // expected wen count
        int          rsc;   // expected rstb cycle (0 = none)
        int          er;    // expected rsp count
        int          rspc;
        logic        ee;
        int          rdy;
        int          ec;
    } vec_t;

    vec_t tv [0:5];
    int   n_bad;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{2'd0, 24'h123456, 32'hCAFEF00D, 32'h0,        32'h0,        1, 0, 0, 0, 1'b0, 2, 0};
        tv[1] = '{2'd1, 24'h000020, 32'h0,        32'hFFFFFFFF, 32'hDEADBEEF, 0, 1, 1, 4, 1'b0, 4, 0};
        tv[2] = '{2'd3, 24'hABCDEF, 32'h0,        32'hFFFFFFFF, 32'h12345678, 0, 1, 1, 4, 1'b0, 4, 0};
        tv[3] = '{2'd2, 24'h000055, 32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFF0000, 1, 2, 1, 5, 1'b0, 5, 0};
        tv[4] = '{2'd2, 24'h000056, 32'h0,        32'h00000001, 32'h00000001, 1, 2, 1, 5, 1'b1, 5, 1};
        tv[5] = '{2'd1, 24'h000057, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 1, 1, 4, 1'b0, 4, 1};
        for (int i = 0; i < 64; i++) rd_tab[i] = 32'h0BAD0BAD;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        cmd_mask = '0; cmd_len = '0; cmd_inc = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_all("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", cmd_ready, 1);
        chk("post_reset_busy", busy, 0);

        // Single-beat vector table.
        for (int i = 0; i < 6; i++) begin
            set_rd(0, tv[i].rdv);
            run(tv[i].op, tv[i].a, tv[i].wd, tv[i].mk, 8'd0, 1'b0, 20);
            chk($sformatf("v%0d_n_wen", i), n_wen, tv[i].ew);
            if (tv[i].ew != 0) begin
                chk($sformatf("v%0d_wen_cyc", i), wen_c[0], 1);
                chk($sformatf("v%0d_wen_addr", i), wen_a[0], tv[i].a);
                chk($sformatf("v%0d_wen_data", i), wen_d[0], tv[i].wd);
            end
            chk($sformatf("v%0d_n_rstb", i), n_rs, (tv[i].rsc != 0) ? 1 : 0);
            if (tv[i].rsc != 0) begin
                chk($sformatf("v%0d_rstb_cyc", i), rs_c[0], tv[i].rsc);
                chk($sformatf("v%0d_rstb_addr", i), rs_a[0], tv[i].a);
            end
            chk($sformatf("v%0d_n_rsp", i), n_rsp, tv[i].er);
            if (tv[i].er != 0) begin
                chk($sformatf("v%0d_rsp_cyc", i), rsp_c[0], tv[i].rspc);
                chk($sformatf("v%0d_rsp_addr", i), rsp_a[0], tv[i].a);
                chk($sformatf("v%0d_rsp_data", i), rsp_d[0], tv[i].rdv);
                chk($sformatf("v%0d_rsp_err", i), rsp_e[0], tv[i].ee);
            end
            chk($sformatf("v%0d_ready_cyc", i), rdy_c, tv[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_err_count", i), err_count, tv[i].ec);
        end

        // Write burst with increment.
        run(2'd0, 24'h000100, 32'hA5000000, 32'h0, 8'd3, 1'b1, 20);
        chk("wb_n_wen", n_wen, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wb_cyc%0d", i), wen_c[i], i + 1);
            chk($sformatf("wb_addr%0d", i), wen_a[i], 24'h000100 + i);
            chk($sformatf("wb_data%0d", i), wen_d[i], 32'hA5000000 + i);
        end
        chk("wb_n_rstb", n_rs, 0);
        chk("wb_ready_cyc", rdy_c, 5);

        // Address and data wrap on a write burst.
        run(2'd0, 24'hFFFFFE, 32'hFFFFFFFF, 32'h0, 8'd1, 1'b1, 20);
        chk("ww_addr0", wen_a[0], 24'hFFFFFE);
        chk("ww_data0", wen_d[0], 32'hFFFFFFFF);
        chk("ww_addr1", wen_a[1], 24'hFFFFFF);
        chk("ww_data1", wen_d[1], 32'h00000000);

        // Address wrap on a read burst; beat period LAT+1.
        set_rd(0, 32'h11111111);
        set_rd(1, 32'h22222222);
        run(2'd1, 24'hFFFFFF, 32'h0, 32'h0, 8'd1, 1'b1, 20);
        chk("wr_n_rstb", n_rs, 2);
        chk("wr_rstb_cyc0", rs_c[0], 1);
        chk("wr_rstb_addr0", rs_a[0], 24'hFFFFFF);
        chk("wr_rstb_cyc1", rs_c[1], 4);
        chk("wr_rstb_addr1", rs_a[1], 24'h000000);
        chk("wr_rsp_cyc0", rsp_c[0], 4);
        chk("wr_rsp_cyc1", rsp_c[1], 7);
        chk("wr_rsp_addr1", rsp_a[1], 24'h000000);
        chk("wr_rsp_data0", rsp_d[0], 32'h11111111);
        chk("wr_rsp_data1", rsp_d[1], 32'h22222222);
        chk("wr_ready_cyc", rdy_c, 7);

        // Verify, masked difference passes.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("vp_pre_err_count", err_count, 0);
        set_rd(0, 32'h0000FFFF);
        set_rd(1, 32'h0001FFFF);
        run(2'd2, 24'h000040, 32'h0000FFFF, 32'h000000FF, 8'd1, 1'b0, 30);
        chk("vp_wen_cyc1", wen_c[1], 5);
        chk("vp_wen_data1", wen_d[1], 32'h0000FFFF);
        chk("vp_rstb_cyc0", rs_c[0], 2);
        chk("vp_rstb_addr1", rs_a[1], 24'h000040);
        chk("vp_rsp_cyc1", rsp_c[1], 9);
        chk("vp_rsp_addr1", rsp_a[1], 24'h000040);
        chk("vp_rsp_err0", rsp_e[0], 0);
        chk("vp_rsp_err1", rsp_e[1], 0);
        chk("vp_ready_cyc", rdy_c, 9);
        @(negedge clk);
        chk("vp_err_count", err_count, 0);

        // Verify, second beat mismatches under the wider mask.
        set_rd(0, 32'h0000FFFF);
        set_rd(1, 32'h0001FFFF);
        run(2'd2, 24'h000040, 32'h0000FFFF, 32'h00FF0000, 8'd1, 1'b0, 30);
        chk("vf_rsp_err0", rsp_e[0], 0);
        chk("vf_rsp_err1", rsp_e[1], 1);
        chk("vf_rsp_data1", rsp_d[1], 32'h0001FFFF);
        @(negedge clk);
        chk("vf_err_count", err_count, 1);

        // Five mismatching verify beats saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) set_rd(i, 32'hFFFFFFFF);
        run(2'd2, 24'h000200, 32'h0, 32'hFFFFFFFF, 8'd4, 1'b1, 40);
        chk("sat_n_rsp", n_rsp, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("sat_rsp_cyc%0d", i), rsp_c[i], 5 + 4 * i);
            chk($sformatf("sat_rsp_addr%0d", i), rsp_a[i], 24'h000200 + i);
            chk($sformatf("sat_rsp_err%0d", i), rsp_e[i], 1);
            chk($sformatf("sat_wen_data%0d", i), wen_d[i], i);
        end
        chk("sat_ready_cyc", rdy_c, 21);
        @(negedge clk);
        chk("sat_err_count", err_count, 3);

        // Clear coincident with a mismatch pulse, then clear alone.
        clr_on_rsp = 1'b1;
        set_rd(0, 32'h00000001);
        run(2'd2, 24'h000300, 32'h0, 32'hFFFFFFFF, 8'd0, 1'b0, 20);
        clr_on_rsp = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_with_pulse", err_count, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_alone", err_count, 0);

        // Maximum burst length: all-ones gives 2**LW beats.
        run(2'd0, 24'h000010, 32'h5, 32'h0, 8'hFF, 1'b0, 300);
        chk("long_n_wen", n_wen, 256);
        chk("long_last_cyc", wen_c[255], 256);
        chk("long_last_addr", wen_a[255], 24'h000010);
        chk("long_ready_cyc", rdy_c, 257);

        // Reset during the second beat of a 4-beat read.
        for (int i = 0; i < 4; i++) set_rd(i, 32'h77770000 + i);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 24'h000300; cmd_wdata = '0;
        cmd_mask = '0; cmd_len = 8'd3; cmd_inc = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mr_beat2_rstb", gb_rstb, 1);
        chk("mr_beat2_addr", gb_addr, 24'h000301);
        chk("mr_beat1_rsp", rsp_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero_all("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid || gb_rstb || gb_wen) n_bad++;
        end
        chk("midrst_no_activity", n_bad, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
